// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller and its queue.
package ifetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fq_entry_t;

    localparam fq_entry_t FQ_EMPTY = '{pc: 32'h0000_0000, inst: NOP};

    // True when a word address lies inside the instruction memory.
    function automatic logic pc_legal(input logic [PC_W-1:0] pc, input int unsigned words);
        return (pc < words);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, inst} between the fetch stage and ID.
// Entry 0 is always the head, so the head outputs come straight from registers.
module fetch_queue
    import ifetch_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    input  logic      i_flush,
    input  logic      i_push,
    input  fq_entry_t i_push_entry,
    input  logic      i_pop,
    output fq_entry_t o_head,
    output logic      o_head_valid,
    output logic [1:0] o_count
);

    fq_entry_t  r_ent0;
    fq_entry_t  r_ent1;
    logic [1:0] r_count;
    logic       r_valid;

    fq_entry_t  w_ent0_nxt;
    fq_entry_t  w_ent1_nxt;
    logic [1:0] w_count_nxt;
    logic       w_pop;
    logic       w_push;

    // Next-state computation; flush dominates push and pop.
    always_comb begin
        w_ent0_nxt  = r_ent0;
        w_ent1_nxt  = r_ent1;
        w_count_nxt = r_count;
        w_pop       = i_pop && (r_count != 2'd0);
        w_push      = i_push && ((r_count != 2'd2) || w_pop);
        if (i_flush) begin
            w_ent0_nxt  = FQ_EMPTY;
            w_ent1_nxt  = FQ_EMPTY;
            w_count_nxt = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        w_ent0_nxt = i_push_entry;
                    end else begin
                        w_ent1_nxt = i_push_entry;
                    end
                    w_count_nxt = r_count + 2'd1;
                end
                2'b01: begin
                    w_ent0_nxt  = r_ent1;
                    w_ent1_nxt  = FQ_EMPTY;
                    w_count_nxt = r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        w_ent0_nxt = i_push_entry;
                    end else begin
                        w_ent0_nxt = r_ent1;
                        w_ent1_nxt = i_push_entry;
                    end
                end
                default: begin
                    w_count_nxt = r_count;
                end
            endcase
        end
    end

    // Queue storage and registered head-valid flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ent0  <= FQ_EMPTY;
            r_ent1  <= FQ_EMPTY;
            r_count <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            r_ent0  <= w_ent0_nxt;
            r_ent1  <= w_ent1_nxt;
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != 2'd0);
        end
    end

    assign o_head       = r_ent0;
    assign o_head_valid = r_valid;
    assign o_count      = r_count;

endmodule

// File: rtl/ifetch_ctrl.sv
// IF-stage controller: owns the PC and fetch FSM, drives MemInstruction
// (boot writes in IDLE, reads in RUN) and feeds ID through fetch_queue.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        boot_valid,
    input  logic [31:0] boot_addr,
    input  logic [31:0] boot_data,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fault
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic         r_fault;

    logic         w_push;
    logic         w_flush;
    logic         w_pop;
    logic         w_space;
    logic [1:0]   w_count;
    fq_entry_t    w_head;
    logic         w_head_valid;
    fq_entry_t    w_push_entry;

    assign w_pop        = w_head_valid && inst_ready;
    assign w_space      = (w_count != 2'd2) || w_pop;
    assign w_push_entry = '{pc: r_pc, inst: mem_rdata};

    // Fetch FSM: halt beats redirect, redirect beats the range check and push.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = RESET_PC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (halt) begin
                    w_state_nxt = HALTED;
                    w_flush     = 1'b1;
                end else if (redirect_valid) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = redirect_pc;
                end else if (!pc_legal(r_pc, MEM_WORDS)) begin
                    w_state_nxt = FAULT;
                    w_flush     = 1'b1;
                end else if (w_space) begin
                    w_push   = 1'b1;
                    w_pc_nxt = r_pc + 32'd1;
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            HALTED: begin
                w_state_nxt = HALTED;
            end
            FAULT: begin
                w_state_nxt = FAULT;
            end
            default: begin
                w_state_nxt = IDLE;
                w_flush     = 1'b1;
            end
        endcase
    end

    // State, PC and sticky fault registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_fault <= r_fault || (w_state_nxt == FAULT);
        end
    end

    // Memory port: boot writes while IDLE (never while reset is asserted), PC reads otherwise.
    always_comb begin
        if (r_state == IDLE) begin
            mem_addr  = boot_addr;
            mem_we    = boot_valid && reset_n;
            mem_wdata = boot_data;
        end else begin
            mem_addr  = r_pc;
            mem_we    = 1'b0;
            mem_wdata = NOP;
        end
    end

    fetch_queue u_fetch_queue (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_flush      (w_flush),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_head_valid (w_head_valid),
        .o_count      (w_count)
    );

    assign inst_valid = w_head_valid;
    assign inst_data  = w_head.inst;
    assign inst_pc    = w_head.pc;
    assign fault      = r_fault;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a behavioural 256-word instruction memory.
module tb_ifetch_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        boot_valid;
    logic [31:0] boot_addr;
    logic [31:0] boot_data;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fault;

    logic [31:0] mem [0:255];
    logic [31:0] prog [0:3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    ifetch_ctrl #(.MEM_WORDS(256), .RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .boot_valid     (boot_valid),
        .boot_addr      (boot_addr),
        .boot_data      (boot_data),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fault          (fault)
    );

    assign mem_rdata = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0000_0000;

    always @(posedge clock) begin
        if (mem_we && (mem_addr < 32'd256)) mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] data);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        chk({tag, "_pc"}, inst_pc, pc);
        chk({tag, "_data"}, inst_data, data);
    endtask

    initial begin
        prog[0] = 32'h8c03_0000;
        prog[1] = 32'h8c04_0001;
        prog[2] = 32'h8c05_0002;
        prog[3] = 32'h8c01_0002;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
        reset_n = 1'b0; start = 1'b0; boot_valid = 1'b0; boot_addr = 32'h0; boot_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0; inst_ready = 1'b0;
        tick; tick;

        // Reset state
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_data", inst_data, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);

        // Boot load in IDLE
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            boot_valid = 1'b1; boot_addr = i; boot_data = prog[i];
            #1;
            chk("boot_we", {31'd0, mem_we}, 32'd1);
            chk("boot_addr", mem_addr, i);
            tick;
        end
        boot_valid = 1'b0;
        chk("boot_mem3", mem[3], prog[3]);

        // Start and stream with ready held high
        start = 1'b1; inst_ready = 1'b1;
        #1;
        chk("start_n_valid", {31'd0, inst_valid}, 32'd0);
        tick;
        start = 1'b0;
        chk("start_n1_valid", {31'd0, inst_valid}, 32'd0);
        chk("start_n1_addr", mem_addr, 32'd0);
        tick;
        chk_head("stream0", 32'd0, prog[0]);
        tick; chk_head("stream1", 32'd1, prog[1]);
        tick; chk_head("stream2", 32'd2, prog[2]);
        tick; chk_head("stream3", 32'd3, prog[3]);

        // Backpressure: ready low for 5 cycles from first valid
        reset_n = 1'b0; inst_ready = 1'b0;
        tick;
        reset_n = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        for (int k = 0; k < 5; k++) begin
            chk_head("bp_hold", 32'd0, prog[0]);
            if (k >= 1) chk("bp_pc", mem_addr, 32'd2);
            tick;
        end
        chk_head("bp_rel0", 32'd0, prog[0]);
        chk("bp_rel_pc", mem_addr, 32'd2);
        inst_ready = 1'b1;
        tick; chk_head("bp_rel1", 32'd1, prog[1]);
        tick; chk_head("bp_rel2", 32'd2, prog[2]);
        tick; chk_head("bp_rel3", 32'd3, prog[3]);

        // Redirect to 1 with head pc 3 and queue full
        redirect_valid = 1'b1; redirect_pc = 32'd1;
        tick;
        redirect_valid = 1'b0;
        chk("redir_bubble", {31'd0, inst_valid}, 32'd0);
        chk("redir_addr", mem_addr, 32'd1);
        tick; chk_head("redir_tgt", 32'd1, prog[1]);
        tick; chk_head("redir_next", 32'd2, prog[2]);

        // Redirect out of range -> fault
        redirect_valid = 1'b1; redirect_pc = 32'd256;
        tick;
        redirect_valid = 1'b0;
        chk("oob_valid", {31'd0, inst_valid}, 32'd0);
        chk("oob_addr", mem_addr, 32'd256);
        tick;
        chk("fault_set", {31'd0, fault}, 32'd1);
        chk("fault_valid", {31'd0, inst_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            boot_valid = 1'b1;
            tick;
            chk("fault_sticky", {31'd0, fault}, 32'd1);
            chk("fault_no_we", {31'd0, mem_we}, 32'd0);
            chk("fault_novalid", {31'd0, inst_valid}, 32'd0);
        end
        boot_valid = 1'b0;
        reset_n = 1'b0;
        tick;
        chk("fault_clr", {31'd0, fault}, 32'd0);
        reset_n = 1'b1;

        // Halt and redirect together: halt wins
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk_head("halt_pre", 32'd0, prog[0]);
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd2;
        tick;
        halt = 1'b0; redirect_valid = 1'b0;
        boot_valid = 1'b1; boot_addr = 32'd0; boot_data = 32'hdead_beef;
        #1;
        chk("halt_valid", {31'd0, inst_valid}, 32'd0);
        chk("halt_no_we", {31'd0, mem_we}, 32'd0);
        tick; tick;
        chk("halt_valid2", {31'd0, inst_valid}, 32'd0);
        chk("halt_no_we2", {31'd0, mem_we}, 32'd0);
        chk("halt_mem0", mem[0], prog[0]);
        boot_valid = 1'b0;

        // Reset mid-stream with boot_valid high
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        chk_head("mid_pre", 32'd1, prog[1]);
        reset_n = 1'b0; boot_valid = 1'b1; boot_addr = 32'd1; boot_data = 32'hdead_beef;
        tick;
        chk("mid_valid", {31'd0, inst_valid}, 32'd0);
        chk("mid_data", inst_data, 32'h0);
        chk("mid_pc", inst_pc, 32'h0);
        chk("mid_we", {31'd0, mem_we}, 32'd0);
        chk("mid_fault", {31'd0, fault}, 32'd0);
        tick;
        chk("mid_mem1", mem[1], prog[1]);
        reset_n = 1'b1;
        #1;
        chk("mid_idle_we", {31'd0, mem_we}, 32'd1);
        boot_valid = 1'b0;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
